// File: rtl/fp12_quad_packer.sv
// fp12_quad_packer: packs a serial FP12 operand stream into four-lane groups
// for the FP12 four-input adder. Short groups close on in_last and are padded.
// One collect buffer and one output buffer absorb a downstream hold.
module fp12_quad_packer #(
  parameter logic [11:0] PAD_VALUE = 12'h000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [11:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             hold,
  output logic             pushin,
  output logic [11:0]      A,
  output logic [11:0]      B,
  output logic [11:0]      C,
  output logic [11:0]      D,
  output logic             grp_last,
  output logic [CNT_W-1:0] grp_count
);

  localparam int unsigned DW    = 12;
  localparam int unsigned LANES = 4;

  // collect buffer
  logic [DW-1:0] c_lane [LANES];
  logic [1:0]    cnt;
  logic          cfull;
  logic          c_last;

  // output buffer
  logic [DW-1:0] o_lane [LANES];
  logic          o_last;
  logic          obuf_v;

  logic          accept_c;
  logic          drain_c;
  logic          close_c;
  logic [DW-1:0] grp_c [LANES];

  // A full collect buffer is the only thing that blocks input.
  assign in_ready = !cfull;

  // Handshake decode and assembly of the group closed by the current beat.
  always_comb begin
    accept_c = in_valid && !cfull;
    drain_c  = obuf_v && !hold;
    close_c  = accept_c && ((cnt == 2'd3) || in_last);
    for (int i = 0; i < LANES; i++) begin
      if (2'(i) < cnt) begin
        grp_c[i] = c_lane[i];
      end else if (2'(i) == cnt) begin
        grp_c[i] = in_data;
      end else begin
        grp_c[i] = PAD_VALUE;
      end
    end
  end

  // Collect buffer: lane fill, and parking a completed group when obuf is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_lane <= '{default: '0};
      cnt    <= 2'd0;
      cfull  <= 1'b0;
      c_last <= 1'b0;
    end else begin
      if (drain_c && cfull) begin
        cfull <= 1'b0;
      end
      if (accept_c) begin
        if (close_c) begin
          cnt <= 2'd0;
          if (obuf_v && !drain_c) begin
            c_lane <= grp_c;
            c_last <= in_last;
            cfull  <= 1'b1;
          end
        end else begin
          c_lane[cnt] <= in_data;
          cnt         <= cnt + 2'd1;
        end
      end
    end
  end

  // Output buffer: refilled from cbuf first, else from a group closing now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_lane <= '{default: '0};
      o_last <= 1'b0;
      obuf_v <= 1'b0;
    end else if (drain_c) begin
      if (cfull) begin
        o_lane <= c_lane;
        o_last <= c_last;
      end else if (close_c) begin
        o_lane <= grp_c;
        o_last <= in_last;
      end else begin
        obuf_v <= 1'b0;
      end
    end else if (close_c && !obuf_v) begin
      o_lane <= grp_c;
      o_last <= in_last;
      obuf_v <= 1'b1;
    end
  end

  // Issue stage: one pushin pulse per drained group; lanes hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pushin    <= 1'b0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      grp_last  <= 1'b0;
      grp_count <= '0;
    end else begin
      pushin <= drain_c;
      if (drain_c) begin
        A         <= o_lane[0];
        B         <= o_lane[1];
        C         <= o_lane[2];
        D         <= o_lane[3];
        grp_last  <= o_last;
        grp_count <= grp_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp12_quad_packer.sv
// Directed testbench for fp12_quad_packer; a second instance with a 4-bit
// group counter shares the stimulus to exercise counter wrap.
`timescale 1ns/1ps
module tb_fp12_quad_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        hold = 1'b0;

  logic        in_ready, pushin, grp_last;
  logic [11:0] A, B, C, D;
  logic [15:0] grp_count;

  logic        in_ready_w, pushin_w, grp_last_w;
  logic [11:0] A_w, B_w, C_w, D_w;
  logic [3:0]  grp_count_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stalls = 0;

  typedef struct {
    logic [47:0] lanes;
    logic        last;
    logic [15:0] cnt;
    int          cyc;
  } push_t;

  push_t pq[$];
  push_t mon_p;

  fp12_quad_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .hold(hold), .pushin(pushin),
    .A(A), .B(B), .C(C), .D(D), .grp_last(grp_last), .grp_count(grp_count)
  );

  fp12_quad_packer #(.PAD_VALUE(12'h000), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_w), .hold(hold), .pushin(pushin_w),
    .A(A_w), .B(B_w), .C(C_w), .D(D_w), .grp_last(grp_last_w),
    .grp_count(grp_count_w)
  );

  always #5 clk = ~clk;

  // Edge counter; pulse records carry the number of the edge that raised pushin.
  always @(posedge clk) cyc = cyc + 1;

  // Record every issued group at the falling edge.
  always @(negedge clk) begin
    if (pushin) begin
      mon_p.lanes = {A, B, C, D};
      mon_p.last  = grp_last;
      mon_p.cnt   = grp_count;
      mon_p.cyc   = cyc;
      pq.push_back(mon_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  // Offer one beat until accepted; acc returns the accepting edge number.
  task automatic send(input logic [11:0] d, input logic l, output int acc);
    int  n;
    logic r;
    n = 0;
    acc = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (acc < 0 && n < 200) begin
      r = in_ready;
      tick();
      if (r) acc = cyc;
      else stalls++;
      n++;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (pushin !== 1'b0) begin errors++; $display("FAIL rst_pushin: got %b want 0", pushin); end
    checks++; if ({A, B, C, D} !== 48'h0) begin errors++; $display("FAIL rst_lanes: got %h want 0", {A, B, C, D}); end
    checks++; if (grp_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", grp_last); end
    checks++; if (grp_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", grp_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] v [8];
    int acc [8];
    int st0;
    v = '{12'h3C0, 12'h400, 12'h420, 12'h440, 12'hBC0, 12'h3C0, 12'h000, 12'h7B0};
    pq.delete();
    st0 = stalls;
    for (int i = 0; i < 8; i++) send(v[i], 1'b0, acc[i]);
    idle(4);
    checks++; if (stalls != st0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stalls - st0); end
    checks++;
    if (pq.size() != 2) begin
      errors++; $display("FAIL b2b_npush: got %0d want 2", pq.size());
    end else begin
      checks++; if (pq[0].lanes !== 48'h3C0_400_420_440) begin errors++; $display("FAIL b2b_g1: got %h want 3c0400420440", pq[0].lanes); end
      checks++; if (pq[1].lanes !== 48'hBC0_3C0_000_7B0) begin errors++; $display("FAIL b2b_g2: got %h want bc03c00007b0", pq[1].lanes); end
      checks++; if (pq[1].cyc - pq[0].cyc != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", pq[1].cyc - pq[0].cyc); end
      checks++; if (pq[0].cyc != acc[3] + 1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", pq[0].cyc, acc[3] + 1); end
      checks++; if (pq[1].last !== 1'b0) begin errors++; $display("FAIL b2b_last: got %b want 0", pq[1].last); end
    end
    checks++; if (grp_count !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", grp_count); end
  endtask

  task automatic test_short_group();
    int acc;
    pq.delete();
    send(12'h3C0, 1'b0, acc);
    send(12'h3C0, 1'b1, acc);
    idle(4);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL short_npush: got %0d want 1", pq.size());
    end else begin
      checks++; if (pq[0].lanes !== 48'h3C0_3C0_000_000) begin errors++; $display("FAIL short_lanes: got %h want 3c03c0000000", pq[0].lanes); end
      checks++; if (pq[0].last !== 1'b1) begin errors++; $display("FAIL short_last: got %b want 1", pq[0].last); end
    end
    checks++; if (grp_count !== 16'd3) begin errors++; $display("FAIL short_count: got %0d want 3", grp_count); end
  endtask

  task automatic test_single_lane_back_to_back();
    int acc;
    int st0;
    pq.delete();
    st0 = stalls;
    send(12'h3C0, 1'b1, acc);
    send(12'hBC0, 1'b1, acc);
    idle(4);
    checks++; if (stalls != st0) begin errors++; $display("FAIL single_stalls: got %0d want 0", stalls - st0); end
    checks++;
    if (pq.size() != 2) begin
      errors++; $display("FAIL single_npush: got %0d want 2", pq.size());
    end else begin
      checks++; if (pq[0].lanes !== 48'h3C0_000_000_000) begin errors++; $display("FAIL single_g1: got %h want 3c0000000000", pq[0].lanes); end
      checks++; if (pq[1].lanes !== 48'hBC0_000_000_000) begin errors++; $display("FAIL single_g2: got %h want bc0000000000", pq[1].lanes); end
      checks++; if (pq[1].cyc - pq[0].cyc != 1) begin errors++; $display("FAIL single_spacing: got %0d want 1", pq[1].cyc - pq[0].cyc); end
      checks++; if ({pq[0].last, pq[1].last} !== 2'b11) begin errors++; $display("FAIL single_last: got %b want 11", {pq[0].last, pq[1].last}); end
    end
  endtask

  task automatic test_last_on_lane3();
    int acc;
    pq.delete();
    send(12'h001, 1'b0, acc);
    send(12'h002, 1'b0, acc);
    send(12'h003, 1'b0, acc);
    send(12'h004, 1'b1, acc);
    idle(4);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL lane3_npush: got %0d want 1", pq.size());
    end else begin
      checks++; if ({pq[0].lanes, pq[0].last} !== {48'h001_002_003_004, 1'b1}) begin
        errors++; $display("FAIL lane3_group: got %h/%b want 001002003004/1", pq[0].lanes, pq[0].last);
      end
    end
  endtask

  task automatic test_stall();
    int acc;
    int st0;
    pq.delete();
    hold = 1'b1;
    st0 = stalls;
    for (int i = 1; i <= 8; i++) send(12'(12'h100 + i), 1'b0, acc);
    checks++; if (stalls != st0) begin errors++; $display("FAIL stall_early: got %0d waits want 0", stalls - st0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_drop: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 12'h109;
    in_last  = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_held: got %b want 0", in_ready); end
    checks++; if (pq.size() != 0) begin errors++; $display("FAIL stall_nopush: got %0d want 0", pq.size()); end
    hold = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    for (int i = 9; i <= 12; i++) send(12'(12'h100 + i), 1'b0, acc);
    idle(4);
    checks++;
    if (pq.size() != 3) begin
      errors++; $display("FAIL stall_npush: got %0d want 3", pq.size());
    end else begin
      checks++; if (pq[1].cyc - pq[0].cyc != 1) begin errors++; $display("FAIL stall_consec: got %0d want 1", pq[1].cyc - pq[0].cyc); end
      checks++; if (pq[0].lanes !== 48'h101_102_103_104) begin errors++; $display("FAIL stall_g1: got %h want 101102103104", pq[0].lanes); end
      checks++; if (pq[1].lanes !== 48'h105_106_107_108) begin errors++; $display("FAIL stall_g2: got %h want 105106107108", pq[1].lanes); end
      checks++; if (pq[2].lanes !== 48'h109_10A_10B_10C) begin errors++; $display("FAIL stall_g3: got %h want 10910a10b10c", pq[2].lanes); end
    end
  endtask

  task automatic test_reset_mid_group();
    int acc;
    send(12'h111, 1'b0, acc);
    send(12'h222, 1'b0, acc);
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    checks++; if (pushin !== 1'b0) begin errors++; $display("FAIL midrst_pushin: got %b want 0", pushin); end
    checks++; if ({A, B, C, D, grp_last} !== 49'h0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", {A, B, C, D, grp_last}); end
    checks++; if (grp_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", grp_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    tick();
    reset = 1'b1;
    pq.delete();
    idle(5);
    checks++; if (pq.size() != 0) begin errors++; $display("FAIL midrst_nopush: got %0d want 0", pq.size()); end
    send(12'h333, 1'b0, acc);
    send(12'h444, 1'b0, acc);
    send(12'h555, 1'b0, acc);
    send(12'h666, 1'b0, acc);
    idle(4);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL midrst_npush: got %0d want 1", pq.size());
    end else begin
      checks++; if (pq[0].lanes !== 48'h333_444_555_666) begin errors++; $display("FAIL midrst_group: got %h want 333444555666", pq[0].lanes); end
      checks++; if (pq[0].cnt !== 16'd1) begin errors++; $display("FAIL midrst_count1: got %0d want 1", pq[0].cnt); end
    end
  endtask

  task automatic test_counter_wrap();
    int acc;
    pulse_reset();
    pq.delete();
    for (int g = 0; g < 17; g++)
      for (int l = 0; l < 4; l++) send(12'(g * 4 + l), 1'b0, acc);
    idle(4);
    checks++; if (pq.size() != 17) begin errors++; $display("FAIL wrap_npush: got %0d want 17", pq.size()); end
    checks++; if (grp_count_w !== 4'h1) begin errors++; $display("FAIL wrap_count4: got %0d want 1", grp_count_w); end
    checks++; if (grp_count !== 16'd17) begin errors++; $display("FAIL wrap_count16: got %0d want 17", grp_count); end
    checks++; if ({A_w, B_w, C_w, D_w} !== 48'h040_041_042_043) begin errors++; $display("FAIL wrap_lanes: got %h want 040041042043", {A_w, B_w, C_w, D_w}); end
  endtask

  task automatic test_valid_gaps();
    logic [11:0] v [4];
    int acc;
    v = '{12'h7B0, 12'h000, 12'hBC0, 12'h041};
    pq.delete();
    for (int i = 0; i < 4; i++) begin
      send(v[i], 1'b0, acc);
      if (i < 3) idle(3);
    end
    idle(4);
    checks++;
    if (pq.size() != 1) begin
      errors++; $display("FAIL gaps_npush: got %0d want 1", pq.size());
    end else begin
      checks++; if (pq[0].lanes !== 48'h7B0_000_BC0_041) begin errors++; $display("FAIL gaps_group: got %h want 7b0000bc0041", pq[0].lanes); end
      checks++; if (pq[0].cyc != acc + 1) begin errors++; $display("FAIL gaps_latency: got %0d want %0d", pq[0].cyc, acc + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_short_group();
    test_single_lane_back_to_back();
    test_last_on_lane3();
    test_stall();
    test_reset_mid_group();
    test_counter_wrap();
    test_valid_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
